mario_motion: RTL and testbench

Player-character motion stage for the game-calculation datapath. It turns button inputs into the character's world position (`char_X`, `char_Y`) and the camera scroll offset (`bg_pos`), which feed the enemy blocks' collision and screen-placement logic directly. Movement advances only on a one-cycle frame tick. The vertical path moves in 1-pixel steps, so downstream equality compares (stomp and side-hit) are never skipped. A `death` pulse from the enemy blocks freezes the character until reset.

---
 rtl/mario_motion.sv | 109 ++++++++++
 tb/tb_mario_motion.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mario_motion.sv
// mario_motion: player-character motion stage.
// Turns button levels into the character's world position and the camera
// scroll offset. Everything advances on a one-cycle frame_tick, apart from
// death, which freezes the character on any cycle until reset.
// Ports:
//   sys_clk, RST_N            clock, async active-low reset
//   frame_tick                one-cycle motion-advance strobe
//   btn_left/right/jump       button levels (synchronous to sys_clk)
//   death                     kill request from the enemy blocks
//   char_X, char_Y            character world position (left / top edge)
//   bg_pos                    camera world X
//   airborne, dead            status flags (registered)
module mario_motion #(
  parameter int START_X   = 20,
  parameter int GROUND_Y  = 80,
  parameter int JUMP_H    = 30,
  parameter int SCROLL_X  = 100,
  parameter int WORLD_MAX = 1000,
  parameter int SCREEN_W  = 320
) (
  input  logic       sys_clk,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       death,
  output logic [9:0] char_X,
  output logic [9:0] char_Y,
  output logic [9:0] bg_pos,
  output logic       airborne,
  output logic       dead
);
  localparam logic [9:0]  X0    = 10'(START_X);
  localparam logic [9:0]  GY    = 10'(GROUND_Y);
  localparam logic [9:0]  JH    = 10'(JUMP_H);
  localparam logic [9:0]  SCR   = 10'(SCROLL_X);
  localparam logic [9:0]  XMAX  = 10'(WORLD_MAX - 12);
  localparam logic [9:0]  BGMAX = 10'(WORLD_MAX - SCREEN_W);

  typedef enum logic [1:0] {GROUND, RISE, FALL, DEAD} state_t;

  state_t     state;
  logic [9:0] rise_cnt;
  logic [9:0] nx, bg_nx, cand;

  // Next horizontal position and camera. Compares precede subtracts so
  // nothing wraps; the lower clamp uses the camera before this tick.
  always_comb begin
    nx    = char_X;
    bg_nx = bg_pos;
    cand  = '0;
    if (btn_right && !btn_left)
      nx = (char_X >= XMAX) ? XMAX : char_X + 10'd1;
    else if (btn_left && !btn_right)
      nx = (char_X > bg_pos) ? char_X - 10'd1 : bg_pos;
    if (nx < bg_pos) nx = bg_pos;
    if (nx > XMAX)   nx = XMAX;
    // 11-bit compare so bg_pos + SCROLL_X cannot overflow.
    if ({1'b0, nx} > ({1'b0, bg_pos} + {1'b0, SCR})) begin
      cand  = nx - SCR;
      bg_nx = (cand > BGMAX) ? BGMAX : cand;
    end
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      state    <= GROUND;
      char_X   <= X0;
      char_Y   <= GY;
      bg_pos   <= '0;
      rise_cnt <= '0;
      airborne <= 1'b0;
      dead     <= 1'b0;
    end else if (state != DEAD && death) begin
      // Death wins over any tick on the same cycle; position freezes.
      state    <= DEAD;
      airborne <= 1'b0;
      dead     <= 1'b1;
    end else if (state != DEAD && frame_tick) begin
      char_X <= nx;
      bg_pos <= bg_nx;
      case (state)
        GROUND: begin
          if (btn_jump) begin
            char_Y   <= GY - 10'd1;
            rise_cnt <= 10'd1;
            airborne <= 1'b1;
            // A one-pixel jump already sits at its apex after this tick.
            state    <= (JH == 10'd1) ? FALL : RISE;
          end
        end
        RISE: begin
          char_Y   <= char_Y - 10'd1;
          rise_cnt <= rise_cnt + 10'd1;
          if (rise_cnt + 10'd1 == JH) state <= FALL;
        end
        FALL: begin
          char_Y <= char_Y + 10'd1;
          if (char_Y + 10'd1 == GY) begin
            state    <= GROUND;
            airborne <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mario_motion.sv
// Randomized bench for mario_motion against a jump-time/position model.
module tb_mario_motion;
  localparam int START_X = 20, GROUND_Y = 80, JUMP_H = 30, SCROLL_X = 100;
  localparam int WORLD_MAX = 1000, SCREEN_W = 320;
  localparam int XMAX = WORLD_MAX - 12, BGMAX = WORLD_MAX - SCREEN_W;

  logic       sys_clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       frame_tick = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_jump = 1'b0, death = 1'b0;
  logic [9:0] char_X, char_Y, bg_pos;
  logic       airborne, dead;

  mario_motion #(
    .START_X(START_X), .GROUND_Y(GROUND_Y), .JUMP_H(JUMP_H),
    .SCROLL_X(SCROLL_X), .WORLD_MAX(WORLD_MAX), .SCREEN_W(SCREEN_W)
  ) dut (
    .sys_clk(sys_clk), .RST_N(RST_N), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .death(death), .char_X(char_X), .char_Y(char_Y), .bg_pos(bg_pos),
    .airborne(airborne), .dead(dead)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0, n_fail = 0;

  // Model: jt counts ticks since take-off (0 = standing).
  int m_x, m_bg, m_jt;
  bit m_dead;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_y();
    if (m_jt <= JUMP_H) return GROUND_Y - m_jt;
    return GROUND_Y - (2 * JUMP_H - m_jt);
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".x"},   int'(char_X),   m_x);
    chk({tag, ".y"},   int'(char_Y),   m_y());
    chk({tag, ".bg"},  int'(bg_pos),   m_bg);
    chk({tag, ".air"}, int'(airborne), (!m_dead && m_jt != 0) ? 1 : 0);
    chk({tag, ".dead"}, int'(dead),    m_dead ? 1 : 0);
  endtask

  task automatic model_reset();
    m_x = START_X; m_bg = 0; m_jt = 0; m_dead = 0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    RST_N = 1'b0; frame_tick = 1'b0; death = 1'b0;
    #2;
    model_reset();
    chk_all("rst");
    @(negedge sys_clk);
    RST_N = 1'b1;
  endtask

  // One clock cycle with the given inputs, then model update and checks.
  task automatic step(input bit tk, input bit l, input bit r, input bit j,
                      input bit d, input string tag);
    int dx, nx;
    frame_tick = tk; btn_left = l; btn_right = r; btn_jump = j; death = d;
    @(posedge sys_clk);
    #1;
    frame_tick = 1'b0; death = 1'b0;
    if (!m_dead) begin
      if (d) m_dead = 1;
      else if (tk) begin
        dx = (r && !l) ? 1 : (l && !r) ? -1 : 0;
        nx = m_x + dx;
        if (nx > XMAX) nx = XMAX;
        if (nx < m_bg) nx = m_bg;
        if (nx - m_bg > SCROLL_X)
          m_bg = (nx - SCROLL_X > BGMAX) ? BGMAX : nx - SCROLL_X;
        m_x = nx;
        if (m_jt == 0) begin
          if (j) m_jt = 1;
        end else begin
          m_jt++;
          if (m_jt == 2 * JUMP_H) m_jt = 0;
        end
      end
    end
    chk_all(tag);
  endtask

  // Random number of non-tick cycles with random buttons; outputs must hold.
  task automatic idle(input string tag);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, tag);
  endtask

  initial begin
    model_reset();
    do_reset();

    for (int i = 0; i < 100; i++) begin
      idle("walk_idle");
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "walk");
    end
    chk("walk_end.x", int'(char_X), 120);
    chk("walk_end.bg", int'(bg_pos), 20);

    for (int t = 1; t <= 60; t++) begin
      step(1'b1, 1'b0, 1'b0, (t == 1 || t == 10), 1'b0, "jump");
      if (t == 30) chk("apex.y", int'(char_Y), 50);
      if (t == 60) chk("land.y", int'(char_Y), 80);
    end

    for (int i = 0; i < 150; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "left");
    chk("left_clamp.x", int'(char_X), 20);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "both");

    for (int i = 0; i < 1200; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "edge");
    chk("edge.x", int'(char_X), 988);
    chk("edge.bg", int'(bg_pos), 680);

    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "dj");
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "dj");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "death");
    chk("death.y", int'(char_Y), 65);
    for (int i = 0; i < 50; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, "frozen");
    do_reset();

    // Death on a tick cycle must win over that tick.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, "death_tick");
    do_reset();

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 499) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
